// File: rtl/dest_track_pipe_pkg.sv
// Shared pipeline types for destination-register tracking.
// Stage record, bubble constant and sizing parameters.
package dest_track_pipe_pkg;

  localparam int REG_COUNT   = 16;
  localparam int STALL_CNT_W = 16;

  typedef struct packed {
    logic [3:0] dest;
    logic       wb_en;
  } stage_t;

  localparam stage_t BUBBLE = '{dest: 4'd0, wb_en: 1'b0};

  // One-hot of the destination, empty for non-writing entries.
  function automatic logic [REG_COUNT-1:0] dest_bit(stage_t s);
    dest_bit = '0;
    if (s.wb_en) dest_bit[s.dest] = 1'b1;
  endfunction

endpackage

// File: rtl/dest_track_pipe_if.sv
// Signal bundle for the destination tracker.
// master drives ID-side controls, slave presents stage state.
interface dest_track_pipe_if;
  import dest_track_pipe_pkg::*;

  logic [3:0]             id_dest;
  logic                   id_wb_en;
  logic                   hazard_detected;
  logic                   flush;
  logic                   freeze;
  logic                   stat_clr;
  logic [3:0]             exe_dest;
  logic [3:0]             mem_dest;
  logic [3:0]             wb_dest;
  logic                   exe_wb_en;
  logic                   mem_wb_en;
  logic                   wb_wb_en;
  logic [REG_COUNT-1:0]   pending_mask;
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    output id_dest, id_wb_en, hazard_detected,
    output flush, freeze, stat_clr,
    input  exe_dest, mem_dest, wb_dest,
    input  exe_wb_en, mem_wb_en, wb_wb_en,
    input  pending_mask, stall_count
  );

  modport slave (
    input  id_dest, id_wb_en, hazard_detected,
    input  flush, freeze, stat_clr,
    output exe_dest, mem_dest, wb_dest,
    output exe_wb_en, mem_wb_en, wb_wb_en,
    output pending_mask, stall_count
  );

endinterface

// File: rtl/dest_stage_reg.sv
// One pipeline stage register: {dest, wb_en}
// with load enable and asynchronous clear to a bubble.
module dest_stage_reg
  import dest_track_pipe_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   en_i,
  input  stage_t d_i,
  output stage_t q_o
);

  stage_t stage_d, stage_q;

  always_comb begin
    stage_d = stage_q;
    if (en_i) stage_d = d_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stage_q <= BUBBLE;
    else     stage_q <= stage_d;
  end

  assign q_o = stage_q;

endmodule

// File: rtl/dest_track_pipe.sv
// Tracks destination registers in EXE/MEM/WB and
// counts hazard stall cycles for the hazard unit.
module dest_track_pipe
  import dest_track_pipe_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             ID_Dest,
  input  logic                   ID_WB_EN,
  input  logic                   hazard_detected,
  input  logic                   flush,
  input  logic                   freeze,
  input  logic                   stat_clr,
  output logic [3:0]             EXE_Dest,
  output logic [3:0]             MEM_Dest,
  output logic [3:0]             WB_Dest,
  output logic                   EXE_WB_EN,
  output logic                   MEM_WB_EN,
  output logic                   WB_WB_EN,
  output logic [REG_COUNT-1:0]   pending_mask,
  output logic [STALL_CNT_W-1:0] stall_count
);

  stage_t next_exe;
  stage_t exe_q, mem_q, wb_q;
  logic   adv;

  logic [STALL_CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  assign adv = ~freeze;

  always_comb begin
    next_exe = BUBBLE;
    if (!(flush || hazard_detected)) begin
      next_exe.dest  = ID_Dest;
      next_exe.wb_en = ID_WB_EN;
    end
  end

  dest_stage_reg u_exe (
    .clk  (clk),
    .rst  (rst),
    .en_i (adv),
    .d_i  (next_exe),
    .q_o  (exe_q)
  );

  dest_stage_reg u_mem (
    .clk  (clk),
    .rst  (rst),
    .en_i (adv),
    .d_i  (exe_q),
    .q_o  (mem_q)
  );

  dest_stage_reg u_wb (
    .clk  (clk),
    .rst  (rst),
    .en_i (adv),
    .d_i  (mem_q),
    .q_o  (wb_q)
  );

  // Only a real stall counts: not frozen, not squashed.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stat_clr) begin
      stall_cnt_d = '0;
    end else if (hazard_detected && !freeze && !flush
                 && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign EXE_Dest     = exe_q.dest;
  assign MEM_Dest     = mem_q.dest;
  assign WB_Dest      = wb_q.dest;
  assign EXE_WB_EN    = exe_q.wb_en;
  assign MEM_WB_EN    = mem_q.wb_en;
  assign WB_WB_EN     = wb_q.wb_en;
  assign stall_count  = stall_cnt_q;
  assign pending_mask = dest_bit(exe_q)
                      | dest_bit(mem_q)
                      | dest_bit(wb_q);

endmodule

// File: doc/dest_track_pipe.md
DEST_TRACK_PIPE -- requirements
Module: dest_track_pipe

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: ID_Dest  input  4  destination register of the instruction in ID.
REQ-004 SHALL have port: ID_WB_EN  input  1  ID instruction writes back.
REQ-005 SHALL have port: hazard_detected  input  1  hazard unit stall request; inserts a bubble into EXE.
REQ-006 SHALL have port: flush  input  1  taken branch; kills the ID instruction.
REQ-007 SHALL have port: freeze  input  1  memory stall; holds every stage.
REQ-008 SHALL have port: stat_clr  input  1  synchronous clear of stall_count.
REQ-009 SHALL have ports EXE_Dest, MEM_Dest, WB_Dest  output  4 each  destination held in that stage.
REQ-010 SHALL have ports EXE_WB_EN, MEM_WB_EN, WB_WB_EN  output  1 each  stage holds a writing instruction.
REQ-011 SHALL have port: pending_mask  output  16  bit r set when any of EXE/MEM/WB has WB_EN=1 with Dest=r.
REQ-012 SHALL have port: stall_count  output  16  saturating count of hazard stall cycles.

Function
REQ-013 SHALL hold three stage registers (EXE, MEM, WB), each {Dest[3:0], WB_EN}; outputs are driven directly from registers (no combinational path from inputs).
REQ-014 SHALL, when freeze=1, hold EXE, MEM and WB unchanged; freeze overrides flush and hazard_detected.
REQ-015 SHALL, when freeze=0, advance: WB<=MEM, MEM<=EXE, EXE<=next_exe.
REQ-016 SHALL set next_exe to a bubble {Dest=0, WB_EN=0} when flush=1 or hazard_detected=1, else {ID_Dest, ID_WB_EN}.
REQ-017 SHALL give latency of exactly 1 cycle ID->EXE, 2 cycles ID->MEM, 3 cycles ID->WB, extended one cycle per frozen cycle.
REQ-018 SHALL compute pending_mask combinationally from registered stage contents only; a bubble contributes nothing; identical Dests in several stages set one bit.
REQ-019 SHALL increment stall_count on each clock edge where hazard_detected=1, freeze=0 and flush=0.
REQ-020 SHALL saturate stall_count at 16'hFFFF (no wrap to 0).
REQ-021 SHALL give stat_clr priority over increment: stall_count<=0 on that edge.
REQ-022 SHALL ignore ID_Dest when ID_WB_EN=0 except that it is still captured into EXE_Dest; consumers gate Dest with WB_EN.

Reset
REQ-023 SHALL, on rst=1, asynchronously clear all stages to bubbles: every Dest=0, every WB_EN=0, pending_mask=0, stall_count=0.
REQ-024 SHALL, on rst assertion mid-operation (including during freeze), discard all in-flight entries; the first edge after deassertion behaves per REQ-014..REQ-016.

Structure
REQ-025 SHALL take the stage record typedef {Dest, WB_EN}, the bubble constant, REG_COUNT=16 and STALL_CNT_W=16 from a shared pipeline package.
REQ-026 SHALL instantiate one sub-module, dest_stage_reg (one stage register with enable and async reset), three times.

Verification
REQ-027 SHALL verify pass-through: ID_Dest=5, ID_WB_EN=1 for one cycle, no stall -> EXE_Dest=5 on cycle 1, MEM_Dest=5 on cycle 2, WB_Dest=5 on cycle 3, with pending_mask=16'h0020 on cycles 1-3 and 0 on cycle 4.
REQ-028 SHALL verify hazard bubble: hazard_detected=1 with ID_Dest=3, ID_WB_EN=1 -> EXE_WB_EN=0 next cycle, stall_count increments by 1, older MEM/WB still advance.
REQ-029 SHALL verify freeze priority: freeze=1, flush=1, hazard_detected=1 for 2 cycles with EXE_Dest=7, EXE_WB_EN=1 -> all stages unchanged and stall_count unchanged.
REQ-030 SHALL verify saturation and clear: preset stall_count to 16'hFFFE via 2 hazard cycles after forcing, then 3 more -> stays 16'hFFFF; stat_clr=1 with hazard_detected=1 -> 0.
REQ-031 SHALL verify reset mid-operation: stages holding Dests 2/4/6 all WB_EN=1, assert rst between edges -> all outputs 0 immediately, before the next clk edge.
REQ-032 SHALL verify duplicate Dests: Dest=9 issued on 3 consecutive cycles -> pending_mask=16'h0200; it clears only after the last copy leaves WB.
